// File: rtl/spike_rate_decoder_if.sv
// Spike-rate decoder bus: neuron-side inputs and rate/display outputs.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             spike_in;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             ovf;
  logic [7:0]       seg;

  // The decoder consumes ena/spike_in and produces the measured rate.
  modport slave (
    input  ena,
    input  spike_in,
    output rate,
    output rate_valid,
    output ovf,
    output seg
  );

  // The neuron/top level drives the spike line and reads the rate.
  modport master (
    output ena,
    output spike_in,
    input  rate,
    input  rate_valid,
    input  ovf,
    input  seg
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of the spike line over a fixed
// window of clock cycles, latches the count as a rate and shows it on a
// 7-segment digit (saturating at F, dp marks >=16 or counter overflow).
// CNT_W must be at least 4 so the low nibble feeds the display directly.
module spike_rate_decoder #(
  parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
  parameter int          CNT_W         = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  spike_rate_decoder_if.slave  bus
);

  localparam logic [23:0]      LAST_POS = WINDOW_CYCLES - 24'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             spikePrev_q;
  logic [23:0]      winCnt_q, winCnt_d;
  logic [CNT_W-1:0] spkCnt_q, spkCnt_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             spikeEdge;
  logic             terminal;
  logic             overSixteen;
  logic [3:0]       digit;
  logic [6:0]       segCode;

  // A held-high spike counts once; the previous level tracks even while disabled.
  assign spikeEdge = bus.spike_in & ~spikePrev_q;
  assign terminal  = (winCnt_q == LAST_POS);

  // Edge-detect history follows the spike line on every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spikePrev_q <= 1'b0;
    else        spikePrev_q <= bus.spike_in;
  end

  // Window/spike counting and rate latch; everything freezes when ena is low.
  always_comb begin
    winCnt_d = winCnt_q;
    spkCnt_d = spkCnt_q;
    sticky_d = sticky_q;
    rate_d   = rate_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (bus.ena) begin
      if (terminal) begin
        winCnt_d = 24'd0;
        valid_d  = 1'b1;
        spkCnt_d = '0;
        sticky_d = 1'b0;
        if (spikeEdge && (spkCnt_q == CNT_MAX)) begin
          rate_d = CNT_MAX;
          ovf_d  = 1'b1;
        end else begin
          rate_d = spikeEdge ? spkCnt_q + CNT_ONE : spkCnt_q;
          ovf_d  = sticky_q;
        end
      end else begin
        winCnt_d = winCnt_q + 24'd1;
        if (spikeEdge) begin
          if (spkCnt_q == CNT_MAX) sticky_d = 1'b1;
          else                     spkCnt_d = spkCnt_q + CNT_ONE;
        end
      end
    end
  end

  // State registers, cleared asynchronously so a reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winCnt_q <= 24'd0;
      spkCnt_q <= '0;
      sticky_q <= 1'b0;
      rate_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      winCnt_q <= winCnt_d;
      spkCnt_q <= spkCnt_d;
      sticky_q <= sticky_d;
      rate_q   <= rate_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  // Display digit saturates at F once the rate no longer fits in one hex digit.
  assign overSixteen = |(rate_q >> 4);
  assign digit       = overSixteen ? 4'hF : rate_q[3:0];

  // Hex digit to segment pattern, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    segCode = 7'h3F;
    case (digit)
      4'h0: segCode = 7'h3F;
      4'h1: segCode = 7'h06;
      4'h2: segCode = 7'h5B;
      4'h3: segCode = 7'h4F;
      4'h4: segCode = 7'h66;
      4'h5: segCode = 7'h6D;
      4'h6: segCode = 7'h7D;
      4'h7: segCode = 7'h07;
      4'h8: segCode = 7'h7F;
      4'h9: segCode = 7'h6F;
      4'hA: segCode = 7'h77;
      4'hB: segCode = 7'h7C;
      4'hC: segCode = 7'h39;
      4'hD: segCode = 7'h5E;
      4'hE: segCode = 7'h79;
      4'hF: segCode = 7'h71;
      default: segCode = 7'h3F;
    endcase
  end

  assign bus.rate       = rate_q;
  assign bus.ovf        = ovf_q;
  assign bus.rate_valid = valid_q;
  assign bus.seg        = {ovf_q | overSixteen, segCode};

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: three instances (16/8, 64/8, 64/4) share
// one stimulus; a window-level reference model checks every cycle, and
// table-driven windows plus hand sequences pin the corner cases.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enaR = 1'b0;
  logic spikeR = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  spike_rate_decoder_if #(.CNT_W(8)) ifA ();
  spike_rate_decoder_if #(.CNT_W(8)) ifB ();
  spike_rate_decoder_if #(.CNT_W(4)) ifC ();

  assign ifA.ena = enaR;  assign ifA.spike_in = spikeR;
  assign ifB.ena = enaR;  assign ifB.spike_in = spikeR;
  assign ifC.ena = enaR;  assign ifC.spike_in = spikeR;

  spike_rate_decoder #(.WINDOW_CYCLES(24'd16), .CNT_W(8)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  spike_rate_decoder #(.WINDOW_CYCLES(24'd64), .CNT_W(8)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  spike_rate_decoder #(.WINDOW_CYCLES(24'd64), .CNT_W(4)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  // Reference model: edges collected per window of enabled cycles.
  int winLen[3] = '{16, 64, 64};
  int maxCnt[3] = '{255, 255, 15};
  int mCycles[3];
  int mEdges[3];
  int mRate[3];
  bit mOvf[3];
  bit mValid[3];
  bit mPrev;

  function automatic logic [7:0] segOf(input int r, input bit o);
    logic [6:0] codes [16];
    int d;
    codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    d = (r < 16) ? r : 15;
    return {o | (r >= 16), codes[d]};
  endfunction

  // Model update on each clock edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPrev = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mCycles[i] = 0; mEdges[i] = 0; mRate[i] = 0; mOvf[i] = 0; mValid[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        mValid[i] = 0;
        if (enaR) begin
          if (spikeR && !mPrev) mEdges[i]++;
          if (mCycles[i] % winLen[i] == winLen[i] - 1) begin
            mRate[i]  = (mEdges[i] > maxCnt[i]) ? maxCnt[i] : mEdges[i];
            mOvf[i]   = (mEdges[i] > maxCnt[i]);
            mValid[i] = 1;
            mEdges[i] = 0;
          end
          mCycles[i]++;
        end
      end
      mPrev = spikeR;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInst(input int i, input int r, input int v, input int o, input int s);
    string tag;
    tag = $sformatf("inst%0d", i);
    checkOutput({tag, ".rate"}, r, mRate[i]);
    checkOutput({tag, ".valid"}, v, int'(mValid[i]));
    checkOutput({tag, ".ovf"}, o, int'(mOvf[i]));
    checkOutput({tag, ".seg"}, s, int'(segOf(mRate[i], mOvf[i])));
  endtask

  // Every falling edge all instances are compared with the model.
  always @(negedge clk) begin
    checkInst(0, int'(ifA.rate), int'(ifA.rate_valid), int'(ifA.ovf), int'(ifA.seg));
    checkInst(1, int'(ifB.rate), int'(ifB.rate_valid), int'(ifB.ovf), int'(ifB.seg));
    checkInst(2, int'(ifC.rate), int'(ifC.rate_valid), int'(ifC.ovf), int'(ifC.seg));
  end

  task automatic applyStimulus(input logic e, input logic s);
    enaR = e;
    spikeR = s;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between clock edges, outputs checked before any edge.
  task automatic resetDut(input string name);
    enaR = 1'b0;
    spikeR = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({name, ".A.rate"}, int'(ifA.rate), 0);
    checkOutput({name, ".A.valid"}, int'(ifA.rate_valid), 0);
    checkOutput({name, ".A.ovf"}, int'(ifA.ovf), 0);
    checkOutput({name, ".A.seg"}, int'(ifA.seg), 8'h3F);
    checkOutput({name, ".C.rate"}, int'(ifC.rate), 0);
    checkOutput({name, ".C.seg"}, int'(ifC.seg), 8'h3F);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         nSpikes;
    int         expRate;
    logic [7:0] expSeg;
    logic       expOvf;
  } winVec_t;

  initial begin
    winVec_t vecs[5];
    vecs[0] = '{5, 5, 8'h6D, 1'b0};
    vecs[1] = '{0, 0, 8'h3F, 1'b0};
    vecs[2] = '{8, 8, 8'h7F, 1'b0};
    vecs[3] = '{1, 1, 8'h06, 1'b0};
    vecs[4] = '{7, 7, 8'h07, 1'b0};

    resetDut("rst0");

    // Table-driven single-cycle spikes on even positions of a 16-cycle window.
    for (int v = 0; v < 5; v++) begin
      for (int p = 0; p < 16; p++) begin
        applyStimulus(1'b1, (p % 2 == 0) && (p / 2 < vecs[v].nSpikes));
        if (p == 14) checkOutput($sformatf("vec%0d.early", v), int'(ifA.rate_valid), 0);
      end
      checkOutput($sformatf("vec%0d.valid", v), int'(ifA.rate_valid), 1);
      checkOutput($sformatf("vec%0d.rate", v), int'(ifA.rate), vecs[v].expRate);
      checkOutput($sformatf("vec%0d.seg", v), int'(ifA.seg), int'(vecs[v].expSeg));
      checkOutput($sformatf("vec%0d.ovf", v), int'(ifA.ovf), int'(vecs[v].expOvf));
    end

    resetDut("rstMid");

    // Enable gap of 10 cycles with a spike rising inside it.
    for (int p = 0; p < 5; p++) applyStimulus(1'b1, p == 1 || p == 3);
    for (int g = 0; g < 10; g++) begin
      applyStimulus(1'b0, g >= 3);
      checkOutput($sformatf("gap%0d.valid", g), int'(ifA.rate_valid), 0);
    end
    for (int p = 5; p < 16; p++) begin
      applyStimulus(1'b1, p < 7);
      if (p == 14) checkOutput("gap.early", int'(ifA.rate_valid), 0);
    end
    checkOutput("gap.valid", int'(ifA.rate_valid), 1);
    checkOutput("gap.rate", int'(ifA.rate), 2);

    // Held level plus terminal-cycle edge, then a level carried into the next window.
    for (int p = 0; p < 16; p++) applyStimulus(1'b1, (p >= 2 && p <= 7) || p == 15);
    checkOutput("held.rate", int'(ifA.rate), 2);
    checkOutput("held.valid", int'(ifA.rate_valid), 1);
    for (int p = 0; p < 16; p++) applyStimulus(1'b1, p < 4);
    checkOutput("carry.rate", int'(ifA.rate), 0);
    checkOutput("carry.valid", int'(ifA.rate_valid), 1);

    resetDut("rstSat");

    // 20 spikes in a 64-cycle window: display saturation and 4-bit overflow.
    for (int p = 0; p < 64; p++) applyStimulus(1'b1, (p % 2 == 0) && (p / 2 < 20));
    checkOutput("sat.B.rate", int'(ifB.rate), 20);
    checkOutput("sat.B.seg", int'(ifB.seg), 8'hF1);
    checkOutput("sat.B.ovf", int'(ifB.ovf), 0);
    checkOutput("sat.C.rate", int'(ifC.rate), 15);
    checkOutput("sat.C.ovf", int'(ifC.ovf), 1);
    checkOutput("sat.C.valid", int'(ifC.rate_valid), 1);
    for (int p = 0; p < 64; p++) applyStimulus(1'b1, (p % 2 == 0) && (p / 2 < 3));
    checkOutput("after.C.rate", int'(ifC.rate), 3);
    checkOutput("after.C.ovf", int'(ifC.ovf), 0);
    checkOutput("after.C.seg", int'(ifC.seg), 8'h4F);
    checkOutput("after.B.rate", int'(ifB.rate), 3);

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      logic e;
      logic s;
      e = ($urandom_range(0, 9) != 0);
      if (n % 400 < 200) s = $urandom_range(0, 1);
      else               s = ($urandom_range(0, 3) == 0) ? ~spikeR : spikeR;
      applyStimulus(e, s);
    end

    resetDut("rstEnd");
    applyStimulus(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
